mem_arbiter: RTL and testbench

//  Shares one single-port synchronous RAM between two requesters: port 0 = processor
//  (fetch/LD/ST), port 1 = program loader/debug master. Round-robin arbitration,
//  one access in flight at a time, per-port req/gnt/rvalid handshake.

---
 rtl/mem_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one single-port synchronous RAM between
// a processor (port 0) and a loader/debug master (port 1), one access in flight.
module mem_arbiter #(
    parameter int AW  = 7,
    parameter int DW  = 16,
    parameter int LAT = 1
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          rvalid0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_t;
    state_t state, state_n;
    logic last, last_n, port, port_n, wr, wr_n, sel;
    logic [1:0] cnt, cnt_n;
    logic gnt0_n, gnt1_n, rvalid0_n, rvalid1_n, mem_en_n, mem_we_n;
    logic [AW-1:0] mem_addr_n;
    logic [DW-1:0] mem_wdata_n, rdata0_n, rdata1_n;

    // On contention the port that did not win last time is served.
    assign sel = req1 && (!req0 || !last);

    always_comb begin
        state_n     = state;
        last_n      = last;
        port_n      = port;
        wr_n        = wr;
        cnt_n       = cnt;
        gnt0_n      = 1'b0;
        gnt1_n      = 1'b0;
        rvalid0_n   = 1'b0;
        rvalid1_n   = 1'b0;
        mem_en_n    = 1'b0;
        mem_we_n    = 1'b0;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        rdata0_n    = rdata0;
        rdata1_n    = rdata1;
        case (state)
            IDLE: if (req0 || req1) begin
                state_n     = ACCESS;
                port_n      = sel;
                last_n      = sel;
                wr_n        = sel ? we1 : we0;
                gnt0_n      = !sel;
                gnt1_n      = sel;
                mem_en_n    = 1'b1;
                mem_we_n    = sel ? we1 : we0;
                mem_addr_n  = sel ? addr1 : addr0;
                mem_wdata_n = sel ? wdata1 : wdata0;
            end
            ACCESS: begin
                state_n = wr ? IDLE : WAIT;
                cnt_n   = 2'(LAT - 1);
            end
            WAIT: if (cnt == 2'd0) begin
                state_n   = IDLE;
                rvalid0_n = !port;
                rvalid1_n = port;
                rdata0_n  = port ? rdata0 : mem_rdata;
                rdata1_n  = port ? mem_rdata : rdata1;
            end else begin
                cnt_n = cnt - 2'd1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state     <= IDLE;
            last      <= 1'b1;
            port      <= 1'b0;
            wr        <= 1'b0;
            cnt       <= 2'd0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata0    <= '0;
            rdata1    <= '0;
        end else begin
            state     <= state_n;
            last      <= last_n;
            port      <= port_n;
            wr        <= wr_n;
            cnt       <= cnt_n;
            gnt0      <= gnt0_n;
            gnt1      <= gnt1_n;
            rvalid0   <= rvalid0_n;
            rvalid1   <= rvalid1_n;
            mem_en    <= mem_en_n;
            mem_we    <= mem_we_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
            rdata0    <= rdata0_n;
            rdata1    <= rdata1_n;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: two arbiters (LAT=1 and LAT=3), each with its own RAM model and
// a transaction-level reference checked every cycle, plus directed literal checks.
module tb_mem_arbiter;
    localparam int AW = 7;
    localparam int DW = 16;
    localparam int N  = 2048;

    logic Clock = 1'b0;
    logic Resetn = 1'b0;
    always #5 Clock = ~Clock;

    logic          req0 [2], we0 [2], req1 [2], we1 [2];
    logic [AW-1:0] addr0 [2], addr1 [2];
    logic [DW-1:0] wdata0 [2], wdata1 [2];
    logic          gnt0 [2], gnt1 [2], rvalid0 [2], rvalid1 [2], mem_en [2], mem_we [2];
    logic [AW-1:0] mem_addr [2];
    logic [DW-1:0] mem_wdata [2], rdata0 [2], rdata1 [2], mem_rdata [2];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        return 16'({9'd0, a} * 16'd257) ^ 16'h5A00;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge Clock);
    endtask

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int L = (g == 0) ? 1 : 3;
        logic [DW-1:0] ram [2**AW];
        bit written [2**AW];
        logic [DW-1:0] pipe [3];

        mem_arbiter #(.AW(AW), .DW(DW), .LAT(L)) dut (
            .Clock(Clock), .Resetn(Resetn),
            .req0(req0[g]), .we0(we0[g]), .addr0(addr0[g]), .wdata0(wdata0[g]),
            .gnt0(gnt0[g]), .rvalid0(rvalid0[g]), .rdata0(rdata0[g]),
            .req1(req1[g]), .we1(we1[g]), .addr1(addr1[g]), .wdata1(wdata1[g]),
            .gnt1(gnt1[g]), .rvalid1(rvalid1[g]), .rdata1(rdata1[g]),
            .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
            .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g])
        );

        // RAM macro: data is garbage except exactly L cycles after a read enable edge
        always @(posedge Clock) begin
            if (mem_en[g] && mem_we[g]) begin
                ram[mem_addr[g]]     <= mem_wdata[g];
                written[mem_addr[g]] <= 1'b1;
            end
            pipe[0] <= (mem_en[g] && !mem_we[g]) ?
                       (written[mem_addr[g]] ? ram[mem_addr[g]] : init_word(mem_addr[g])) : 16'hDEAD;
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
        end
        assign mem_rdata[g] = pipe[L-1];

        // Reference: grant whenever free and requested; a transaction occupies the RAM
        // for 2 cycles (write) or L+2 cycles (read) and its effects are scheduled by cycle.
        logic [DW-1:0] mref [2**AW];
        bit mw [2**AW];
        int free_at = 0;
        bit last = 1'b1;
        bit [1:0] e_gnt [N], e_rv [N];
        bit e_en [N], e_we [N], e_set [N], e_rst [N];
        logic [AW-1:0] e_addr [N];
        logic [DW-1:0] e_wd [N], e_rd [N];
        logic [AW-1:0] h_addr;
        logic [DW-1:0] h_wd, h_rd0, h_rd1;

        always @(posedge Clock) begin
            int t;
            bit p, w;
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            t = cyc;
            if (t + 8 < N) begin
                if (!Resetn) begin
                    for (int k = t + 1; k <= t + 8; k++) begin
                        e_gnt[k] = 0; e_rv[k] = 0; e_en[k] = 0; e_we[k] = 0; e_set[k] = 0;
                    end
                    e_rst[t+1] = 1;
                    free_at = t + 1;
                    last = 1;
                end else if (t >= free_at && (req0[g] || req1[g])) begin
                    p = (req0[g] && req1[g]) ? !last : req1[g];
                    w = p ? we1[g] : we0[g];
                    a = p ? addr1[g] : addr0[g];
                    d = p ? wdata1[g] : wdata0[g];
                    last = p;
                    e_gnt[t+1] = p ? 2'b10 : 2'b01;
                    e_en[t+1] = 1; e_we[t+1] = w; e_set[t+1] = 1;
                    e_addr[t+1] = a; e_wd[t+1] = d;
                    if (w) begin
                        mref[a] = d; mw[a] = 1;
                        free_at = t + 2;
                    end else begin
                        e_rv[t+2+L] = p ? 2'b10 : 2'b01;
                        e_rd[t+2+L] = mw[a] ? mref[a] : init_word(a);
                        free_at = t + 2 + L;
                    end
                end
            end
        end

        always @(negedge Clock) begin
            if (cyc >= 1 && cyc < N) begin
                if (e_rst[cyc]) begin h_addr = '0; h_wd = '0; h_rd0 = '0; h_rd1 = '0; end
                if (e_set[cyc]) begin h_addr = e_addr[cyc]; h_wd = e_wd[cyc]; end
                if (e_rv[cyc][0]) h_rd0 = e_rd[cyc];
                if (e_rv[cyc][1]) h_rd1 = e_rd[cyc];
                chk($sformatf("model%0d_cyc%0d", g, cyc),
                    64'({gnt1[g], gnt0[g], rvalid1[g], rvalid0[g], mem_en[g], mem_we[g],
                         mem_addr[g], mem_wdata[g], rdata0[g], rdata1[g]}),
                    64'({e_gnt[cyc], e_rv[cyc], e_en[cyc], e_we[cyc], h_addr, h_wd, h_rd0, h_rd1}));
            end
        end
    end

    initial begin
        logic [15:0] seq;
        int ngnt;
        for (int g = 0; g < 2; g++) begin
            req0[g] = 0; we0[g] = 0; addr0[g] = '0; wdata0[g] = '0;
            req1[g] = 0; we1[g] = 0; addr1[g] = '0; wdata1[g] = '0;
        end
        step(3);
        Resetn = 1;
        step(1);
        chk("rst_flags", 64'({gnt1[0], gnt0[0], rvalid1[0], rvalid0[0], mem_en[0], mem_we[0]}), 64'd0);
        chk("rst_data", 64'({mem_addr[0], mem_wdata[0], rdata0[0], rdata1[0]}), 64'd0);
        // write alone from port 0
        req0[0] = 1; we0[0] = 1; addr0[0] = 7'h05; wdata0[0] = 16'h1234;
        step(1);
        chk("t1_gnt", 64'({gnt1[0], gnt0[0]}), 64'b01);
        chk("t1_mem", 64'({mem_en[0], mem_we[0], mem_addr[0], mem_wdata[0]}), 64'({2'b11, 7'h05, 16'h1234}));
        req0[0] = 0;
        step(1);
        chk("t1_after", 64'({gnt0[0], mem_en[0], mem_we[0], rvalid0[0]}), 64'd0);
        chk("t1_hold", 64'({mem_addr[0], mem_wdata[0]}), 64'({7'h05, 16'h1234}));
        // port 1 reads it back
        req1[0] = 1; we1[0] = 0; addr1[0] = 7'h05;
        step(1);
        chk("t2_gnt", 64'({gnt1[0], gnt0[0]}), 64'b10);
        req1[0] = 0;
        step(1);
        chk("t2_wait", 64'({rvalid1[0], rvalid0[0]}), 64'd0);
        step(1);
        chk("t2_rvalid", 64'({rvalid1[0], rvalid0[0]}), 64'b10);
        chk("t2_rdata1", 64'(rdata1[0]), 64'h1234);
        chk("t2_rdata0", 64'(rdata0[0]), 64'h0);
        // continuous contention of reads
        req0[0] = 1; we0[0] = 0; addr0[0] = 7'h10;
        req1[0] = 1; we1[0] = 0; addr1[0] = 7'h20;
        seq = 0; ngnt = 0;
        repeat (12) begin
            step(1);
            if (gnt0[0] && gnt1[0]) chk("t3_both_gnt", 64'd1, 64'd0);
            if (gnt0[0]) begin seq = {seq[11:0], 4'h0}; ngnt++; end
            if (gnt1[0]) begin seq = {seq[11:0], 4'h1}; ngnt++; end
        end
        req0[0] = 0; req1[0] = 0;
        chk("t3_count", 64'(ngnt), 64'd4);
        chk("t3_order", 64'(seq), 64'h0101);
        chk("t3_rdata", 64'({rdata0[0], rdata1[0]}), 64'({16'h4A10, 16'h7A20}));
        step(2);
        // request held past the grant
        req0[0] = 1; we0[0] = 1; addr0[0] = 7'h07; wdata0[0] = 16'hBEEF;
        step(1);
        chk("t6_gnt", 64'(gnt0[0]), 64'd1);
        step(1);
        chk("t6_no_double", 64'(gnt0[0]), 64'd0);
        req0[0] = 0;
        step(1);
        chk("t6_no_regrant", 64'(gnt0[0]), 64'd0);
        req0[0] = 1;
        step(1);
        chk("t6b_gnt", 64'(gnt0[0]), 64'd1);
        step(1);
        chk("t6b_access", 64'(gnt0[0]), 64'd0);
        step(1);
        chk("t6b_regrant", 64'(gnt0[0]), 64'd1);
        req0[0] = 0;
        step(2);
        // reset during the wait of a port 0 read
        req0[0] = 1; we0[0] = 0; addr0[0] = 7'h05;
        step(1);
        chk("t5_gnt", 64'(gnt0[0]), 64'd1);
        req0[0] = 0;
        step(1);
        Resetn = 0;
        step(1);
        chk("t5_zero", 64'({gnt1[0], gnt0[0], rvalid1[0], rvalid0[0], mem_en[0], mem_we[0],
                            mem_addr[0], mem_wdata[0], rdata0[0], rdata1[0]}), 64'd0);
        Resetn = 1;
        req0[0] = 1; addr0[0] = 7'h10; req1[0] = 1; we1[0] = 0; addr1[0] = 7'h20;
        step(1);
        chk("t5_first", 64'({gnt1[0], gnt0[0], rvalid0[0]}), 64'b010);
        req0[0] = 0;
        step(3);
        chk("t5_second", 64'({gnt1[0], gnt0[0]}), 64'b10);
        req1[0] = 0;
        step(3);
        // LAT=3 single read
        req0[1] = 1; we0[1] = 0; addr0[1] = 7'h05;
        step(1);
        chk("t4_gnt", 64'(gnt0[1]), 64'd1);
        req0[1] = 0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk($sformatf("t4_wait%0d", i), 64'(rvalid0[1]), 64'd0);
        end
        step(1);
        chk("t4_rvalid", 64'(rvalid0[1]), 64'd1);
        chk("t4_rdata", 64'(rdata0[1]), 64'h5F05);
        req1[1] = 1; we1[1] = 1; addr1[1] = 7'h09; wdata1[1] = 16'hA5A5;
        step(1);
        req1[1] = 0;
        step(1);
        req0[1] = 1; addr0[1] = 7'h09;
        step(1);
        req0[1] = 0;
        step(5);
        chk("t4_rdata_wr", 64'(rdata0[1]), 64'hA5A5);
        step(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
